// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: operands are fed LSB-first through one full-subtractor
// cell, with the borrow carried between bits in a flip-flop.

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign busy        = (state == RUN) || (state == DONE);
  assign diff        = diff_sr;
  assign bout        = brw;
  assign accept      = start_valid && start_ready;
  assign last_bit    = (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last_bit) state_next = DONE;
      DONE: if (done_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // diff_sr keeps its old value on accept; only RUN edges shift new bits in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
          brw     <= cell_bout;
          cnt     <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a WIDTH=8 instance for directed and random
// operations, and a WIDTH=2 instance swept exhaustively.

module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic [7:0] diff;
  logic       bout;
  logic       done_valid;
  logic       done_ready;
  logic       busy;

  logic       w2_start_valid;
  logic       w2_start_ready;
  logic [1:0] w2_a;
  logic [1:0] w2_b;
  logic       w2_bin;
  logic [1:0] w2_diff;
  logic       w2_bout;
  logic       w2_done_valid;
  logic       w2_done_ready;
  logic       w2_busy;

  int checks = 0;
  int errors = 0;
  int issued8 = 0;
  int handshakes8 = 0;
  logic [8:0] sb8[$];
  logic [2:0] sb2[$];

  serial_subtractor #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .bin         (bin),
    .diff        (diff),
    .bout        (bout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  serial_subtractor #(.WIDTH(2)) dut_w2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (w2_start_valid),
    .start_ready (w2_start_ready),
    .a           (w2_a),
    .b           (w2_b),
    .bin         (w2_bin),
    .diff        (w2_diff),
    .bout        (w2_bout),
    .done_valid  (w2_done_valid),
    .done_ready  (w2_done_ready),
    .busy        (w2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && done_valid && done_ready) handshakes8++;
  end

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] x, input logic [1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {2'd0, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one WIDTH=8 operation; called and returns at a falling edge.
  task automatic applyStimulus(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v,
                               input int stall, input bit pulse_start);
    int lat;
    logic [8:0] exp_v;
    lat = 0;
    while (!start_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!start_ready) checkOutput("start_ready_timeout", {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    a = a_v;
    b = b_v;
    bin = bin_v;
    @(posedge clk);
    #1;
    sb8.push_back(model8(a_v, b_v, bin_v));
    issued8++;
    start_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!done_valid && lat < 50) begin
      if (pulse_start) begin
        checkOutput("start_ready_run", {31'd0, start_ready}, 32'd0);
        start_valid = ~start_valid;
      end
      lat++;
      @(negedge clk);
    end
    checkOutput("latency", lat, 32'd8);
    exp_v = (sb8.size() != 0) ? sb8.pop_front() : 9'h1ff;
    checkOutput("result", {23'd0, bout, diff}, {23'd0, exp_v});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("hold", {22'd0, done_valid, bout, diff}, {22'd0, 1'b1, exp_v});
      if (pulse_start) begin
        checkOutput("start_ready_done", {31'd0, start_ready}, 32'd0);
        start_valid = ~start_valid;
      end
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    @(negedge clk);
    checkOutput("idle_after", {29'd0, start_ready, done_valid, busy}, 32'b100);
  endtask

  task automatic runW2(input logic [1:0] a_v, input logic [1:0] b_v, input logic c);
    int lat;
    logic [2:0] exp_v;
    lat = 0;
    while (!w2_start_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!w2_start_ready) checkOutput("w2_start_timeout", {31'd0, w2_start_ready}, 32'd1);
    w2_start_valid = 1'b1;
    w2_a = a_v;
    w2_b = b_v;
    w2_bin = c;
    @(posedge clk);
    #1;
    sb2.push_back(model2(a_v, b_v, c));
    w2_start_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!w2_done_valid && lat < 20) begin
      lat++;
      @(negedge clk);
    end
    checkOutput("w2_latency", lat, 32'd2);
    exp_v = (sb2.size() != 0) ? sb2.pop_front() : 3'b111;
    checkOutput("w2_result", {29'd0, w2_bout, w2_diff}, {29'd0, exp_v});
  endtask

  initial begin
    rst_n = 1'b0;
    start_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    done_ready = 1'b0;
    w2_start_valid = 1'b0;
    w2_a = '0;
    w2_b = '0;
    w2_bin = 1'b0;
    w2_done_ready = 1'b1;

    @(negedge clk);
    checkOutput("reset_state", {20'd0, start_ready, done_valid, busy, bout, diff}, {20'd0, 3'b100, 9'd0});
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    applyStimulus(8'h00, 8'h01, 1'b0, 0, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    applyStimulus(8'h80, 8'h7F, 1'b1, 0, 1'b0);

    $display("[TB] backpressure with start pulses");
    applyStimulus(8'hC3, 8'h4D, 1'b1, 5, 1'b1);

    $display("[TB] reset mid-operation");
    start_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid", {20'd0, start_ready, done_valid, busy, bout, diff}, {20'd0, 3'b100, 9'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h10, 8'h01, 1'b0, 0, 1'b0);

    $display("[TB] WIDTH=2 exhaustive");
    for (int i = 0; i < 32; i++) begin
      runW2(2'(i >> 3), 2'(i >> 1), 1'(i));
    end

    $display("[TB] randomised operations");
    for (int n = 0; n < 1000; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("handshakes", handshakes8, issued8);
    checkOutput("sb8_empty", sb8.size(), 32'd0);
    checkOutput("sb2_empty", sb2.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
